// File: rtl/axis_rate_limiter_if.sv
// rtl/axis_rate_limiter_if.sv - AXI4-Stream bundle used on both sides of the rate limiter
//
// Signals: tdata/tstrb/tuser/tvalid/tlast flow master -> slave, tready flows slave -> master.
// Modports: master (drives the beat, samples tready), slave (samples the beat, drives tready).
interface axis_rate_limiter_if #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (
        output tdata,
        output tstrb,
        output tuser,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tstrb,
        input  tuser,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_rate_limiter.sv
// rtl/axis_rate_limiter.sv - token-bucket egress shaper admitting whole AXI4-Stream packets
//
// Ports:
//   axi_aclk, axi_aresetn      clock, asynchronous active-low reset
//   s_axis (slave modport)     upstream stream; tready is gated at packet boundaries
//   m_axis (master modport)    downstream stream; data/strb/user/last pass straight through
//   cfg_enable                 1 = shaping active, 0 = transparent (bucket held at ceiling)
//   cfg_rate                   refill per cycle in 1/256 byte
//   cfg_burst                  bucket ceiling in bytes (ceiling = cfg_burst << 8)
//   stat_clear                 synchronous clear of both statistics counters
//   stat_pkts                  count of tlast transfers
//   stat_throttle              count of cycles with upstream tvalid while the gate is closed
module axis_rate_limiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int BUCKET_WIDTH       = 32
) (
    input  logic                axi_aclk,
    input  logic                axi_aresetn,
    axis_rate_limiter_if.slave  s_axis,
    axis_rate_limiter_if.master m_axis,
    input  logic                cfg_enable,
    input  logic [15:0]         cfg_rate,
    input  logic [15:0]         cfg_burst,
    input  logic                stat_clear,
    output logic [31:0]         stat_pkts,
    output logic [31:0]         stat_throttle
);
    localparam int STRB_WIDTH = C_AXIS_DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = $clog2(STRB_WIDTH + 1);
    // One extra bit so refill and debit can never wrap before clamping.
    localparam int WIDE       = BUCKET_WIDTH + 1;

    localparam logic signed [WIDE-1:0] BUCKET_MIN = {2'b11, {(BUCKET_WIDTH-1){1'b0}}};
    localparam logic signed [WIDE-1:0] BUCKET_MAX = {2'b00, {(BUCKET_WIDTH-1){1'b1}}};

    logic signed [BUCKET_WIDTH-1:0] bucket;
    logic signed [BUCKET_WIDTH-1:0] bucket_next;
    logic                           in_pkt;
    logic                           gate;
    logic                           fire;
    logic [CNT_WIDTH-1:0]           strb_count;
    logic signed [WIDE-1:0]         ceiling;
    logic signed [WIDE-1:0]         refill;
    logic signed [WIDE-1:0]         sum;
    logic signed [WIDE-1:0]         sat;
    logic signed [WIDE-1:0]         debit;
    logic signed [WIDE-1:0]         diff;

    // Pin a widened value into the bucket's range; used for both the
    // debit floor and for ceilings that would not fit a narrow bucket.
    function automatic logic signed [BUCKET_WIDTH-1:0] clamp_bucket(input logic signed [WIDE-1:0] v);
        logic signed [WIDE-1:0] c;
        if (v < BUCKET_MIN) begin
            c = BUCKET_MIN;
        end else if (v > BUCKET_MAX) begin
            c = BUCKET_MAX;
        end else begin
            c = v;
        end
        return c[BUCKET_WIDTH-1:0];
    endfunction

    // Admission depends only on state and upstream tvalid, never on
    // m_axis.tready, so downstream ready cannot loop back into tvalid.
    assign gate = ~cfg_enable | in_pkt | ~bucket[BUCKET_WIDTH-1];

    assign m_axis.tdata  = s_axis.tdata;
    assign m_axis.tstrb  = s_axis.tstrb;
    assign m_axis.tuser  = s_axis.tuser;
    assign m_axis.tlast  = s_axis.tlast;
    assign m_axis.tvalid = s_axis.tvalid & gate;
    assign s_axis.tready = m_axis.tready & gate;

    assign fire = s_axis.tvalid & s_axis.tready;

    always_comb begin
        strb_count = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            strb_count = strb_count + CNT_WIDTH'(s_axis.tstrb[i]);
        end
    end

    always_comb begin
        ceiling     = $signed({{(WIDE-24){1'b0}}, cfg_burst, 8'd0});
        refill      = $signed({{(WIDE-16){1'b0}}, cfg_rate});
        sum         = $signed({bucket[BUCKET_WIDTH-1], bucket}) + refill;
        sat         = (sum > ceiling) ? ceiling : sum;
        debit       = '0;
        if (fire) begin
            debit = $signed({{(WIDE-CNT_WIDTH-8){1'b0}}, strb_count, 8'd0});
        end
        diff        = sat - debit;
        bucket_next = cfg_enable ? clamp_bucket(diff) : clamp_bucket(ceiling);
    end

    // in_pkt keeps the gate open for the rest of an admitted packet, which
    // is what lets a packet run the bucket into debt without being split.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            bucket <= '0;
            in_pkt <= 1'b0;
        end else begin
            bucket <= bucket_next;
            if (fire) begin
                in_pkt <= ~s_axis.tlast;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            stat_pkts     <= '0;
            stat_throttle <= '0;
        end else if (stat_clear) begin
            stat_pkts     <= '0;
            stat_throttle <= '0;
        end else begin
            if (fire && s_axis.tlast) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
            if (s_axis.tvalid && !gate) begin
                stat_throttle <= stat_throttle + 32'd1;
            end
        end
    end
endmodule
